dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised, handshaked data memory for the pipelined core's MEM stage. It replaces the flat 64-bit-word data memory with a byte-addressed store. It supports RISC-V load/store sizes (B/H/W/D) with sign or zero extension, detects misaligned and out-of-range accesses, and has a configurable access latency so the pipeline can exercise stall logic. Sole master is the MEM stage; the stage stalls while `req_ready` is low or a response is outstanding.

## Interface
Parameters:
- `DEPTH`, 1024: number of 64-bit words; power of two, ≥2.
- `LATENCY`, 1: cycles from request acceptance to response, 1..8.
- `INIT_INDEX`, 1: 1 = word i initialised to i on reset; 0 = all zeros.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 double.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-aligned (low bytes used).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_error` out 1: misaligned or out-of-range; qualified by `resp_valid`.

## Operation
- Storage is little-endian. Word index = `req_addr[3+log2(DEPTH)-1:3]`. Byte lane = `req_addr[2:0]`.
- Out-of-range: any bit of `req_addr[63:3+log2(DEPTH)]` is set.
- Misaligned: the address is not a multiple of 2^`req_size` bytes.
- Error has priority. An errored store writes nothing. An errored load returns 0 with `resp_error`=1.
- State machine has three states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid` at a clock edge the request is accepted. The next state is RESP if `LATENCY`=1, otherwise WAIT with the counter loaded to `LATENCY`-1.
  - WAIT: `req_ready`=0. The counter decrements each cycle. The state moves to RESP when the counter reaches 1.
  - RESP: `resp_valid`=1 and `req_ready`=0 for exactly one cycle, then IDLE.
- Stores commit at the acceptance edge. Only the 1/2/4/8 byte lanes selected by size and lane are written; other bytes are unchanged.
- Loads sample the word at the acceptance edge into a holding register. The selected bytes are shifted to bit 0 and extended per `req_unsigned`; D-size ignores `req_unsigned`.
- `resp_rdata` and `resp_error` are registered. They hold their value only while `resp_valid`=1 and are 0 otherwise.
- Request inputs are ignored outside IDLE. Holding `req_valid` high is legal.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, state IDLE, counter 0.
- On reset, every array word is set to i (`INIT_INDEX`=1) or 0.
- Reset asserted mid-WAIT or mid-RESP aborts the access: no response is issued, and a store already committed is overwritten by reinitialisation.
- Acceptance at edge k puts `resp_valid` high during the cycle following edge k+`LATENCY`-1.
- `req_ready` returns high in the cycle after the RESP cycle.
- Maximum throughput is one access per `LATENCY`+1 cycles.
- No combinational path exists from request inputs to any output.
- Address arithmetic is unsigned 64-bit; no wrap-around past `DEPTH`, because such addresses are errors.

## Test plan
- **Reset and basic load:** `INIT_INDEX`=1, `LATENCY`=2. Reset, then LD at 0x28 → `resp_valid` one cycle, 2 cycles after acceptance; `resp_rdata`=5; `resp_error`=0.
- **Sized store and reload:** SB 0xFF at 0x09.
  - LB 0x09 → 0xFFFF_FFFF_FFFF_FFFF.
  - LBU 0x09 → 0xFF.
  - LD 0x08 → 0x0000_0000_0000_FF01.
  - SH 0x8001 at 0x0E, then LH 0x0E → 0xFFFF_FFFF_FFFF_8001.
- **Misalignment:** LW 0x0A → `resp_error`=1, `resp_rdata`=0. SD 0x1234 at 0x0C → error, and a following LD 0x08 is unchanged.
- **Out of range:** LD at 8*`DEPTH` (0x2000) → `resp_error`=1. SB at 0xFFFF_FFFF_FFFF_FFF8 → error, with no write to word 1023.
- **Back-to-back:** `req_valid` held high for 4 requests with `LATENCY`=3 → `req_ready` pattern is 1,0,0,0 repeating; exactly 4 `resp_valid` pulses, 4 cycles apart.
- **Reset mid-access:** assert `reset` during WAIT after an SD 0xDEAD at 0x10.
  - No `resp_valid` appears.
  - `req_ready`=1 after release.
  - LD 0x10 → 2.

Source files
------------

// File: rtl/dmem_lsu.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Byte-addressed, handshaked data memory for the MEM stage.
//            Supports B/H/W/D loads and stores, sign/zero extension,
//            misalignment and out-of-range detection, and a configurable
//            response latency so the pipeline stall logic gets exercised.
// Ports    : clock, reset (async, active-high)
//            req_valid/req_ready  request handshake
//            req_write, req_size, req_unsigned, req_addr, req_wdata
//            resp_valid           one-cycle response pulse
//            resp_rdata           extended load data (0 for stores/errors)
//            resp_error           misaligned or out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1,
  parameter bit INIT_INDEX = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   hold_data;
  logic          hold_error;

  logic [AW-1:0] word_idx;
  logic [2:0]    lane;
  logic [5:0]    shamt;
  logic          out_of_range;
  logic          misaligned;
  logic          acc_error;
  logic [63:0]   cur_word;
  logic [63:0]   size_mask;
  logic [63:0]   lane_mask;
  logic [63:0]   store_word;
  logic [63:0]   shifted;
  logic [63:0]   load_ext;
  logic [63:0]   load_result;

  // Request decode. Everything here only feeds registers, so there is no
  // combinational path from the request inputs to any output.
  always_comb begin
    word_idx     = req_addr[3 +: AW];
    lane         = req_addr[2:0];
    shamt        = {lane, 3'b000};
    out_of_range = |req_addr[63:3+AW];

    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = |lane[1:0];
      default: misaligned = |lane;
    endcase
    acc_error = out_of_range | misaligned;

    case (req_size)
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase

    // Aligned accesses never straddle a word, so a plain shift places the
    // store bytes and the lane mask in the right byte positions.
    cur_word   = mem[word_idx];
    lane_mask  = size_mask << shamt;
    store_word = (cur_word & ~lane_mask) | ((req_wdata << shamt) & lane_mask);

    shifted = cur_word >> shamt;
    case (req_size)
      2'b00:   load_ext = req_unsigned ? {56'b0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = req_unsigned ? {48'b0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = req_unsigned ? {32'b0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase

    load_result = (acc_error | req_write) ? 64'd0 : load_ext;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      hold_data  <= '0;
      hold_error <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_INDEX ? 64'(i) : 64'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            hold_data  <= load_result;
            hold_error <= acc_error;
            // Stores commit at acceptance; an errored store writes nothing.
            if (req_write && !acc_error) begin
              mem[word_idx] <= store_word;
            end
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_result;
              resp_error <= acc_error;
            end else begin
              state <= WAIT;
              count <= CW'(LATENCY - 1);
            end
          end
        end

        WAIT: begin
          if (count == CW'(1)) begin
            state      <= RESP;
            count      <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= hold_data;
            resp_error <= hold_error;
          end else begin
            count <= count - CW'(1);
          end
        end

        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_error <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Self-checking bench for dmem_lsu. Instance 0 runs LATENCY=2,
//            instance 1 runs LATENCY=3; both compared against a byte-array
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

  localparam int DEPTH = 1024;
  localparam int NB    = 8 * DEPTH;

  logic        clock = 1'b0;
  logic        reset        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [63:0] req_addr     [2];
  logic [63:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic [63:0] resp_rdata   [2];
  logic        resp_error   [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mdl [2][NB];

  always #5 clock = ~clock;

  dmem_lsu #(.DEPTH(DEPTH), .LATENCY(2), .INIT_INDEX(1'b1)) u_l2 (
    .clock(clock), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  dmem_lsu #(.DEPTH(DEPTH), .LATENCY(3), .INIT_INDEX(1'b1)) u_l3 (
    .clock(clock), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  // ---------------- reference model (byte-addressed array) ----------------
  task automatic m_reset(input int d);
    logic [63:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = 64'(i);
      for (int b = 0; b < 8; b++) begin
        mdl[d][8*i+b] = w[8*b +: 8];
      end
    end
  endtask

  function automatic bit m_err(input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] nbytes;
    nbytes = 64'd1 << sz;
    return (a >= 64'(NB)) || ((a % nbytes) != 64'd0);
  endfunction

  function automatic logic [63:0] m_load(input int d, input logic [63:0] a,
                                         input logic [1:0] sz, input bit uns);
    int          nb;
    logic [63:0] v;
    nb = 1 << sz;
    v  = 64'd0;
    for (int b = 0; b < nb; b++) begin
      v = v | (64'(mdl[d][int'(a) + b]) << (8 * b));
    end
    if (!uns && nb < 8 && v[8*nb-1]) begin
      v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    end
    return v;
  endfunction

  task automatic m_store(input int d, input logic [63:0] a,
                         input logic [1:0] sz, input logic [63:0] wd);
    int nb;
    nb = 1 << sz;
    for (int b = 0; b < nb; b++) begin
      mdl[d][int'(a) + b] = wd[8*b +: 8];
    end
  endtask

  // ---------------- comparison helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'b0, obs}, {63'b0, exp});
  endtask

  // One complete access: drive, wait (bounded) for the response, check
  // latency, data, error, pulse width and ready recovery against the model.
  task automatic access(input int d, input bit wr, input logic [1:0] sz,
                        input bit uns, input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er);
    logic [63:0] exp_d;
    bit          exp_e;
    int          n;
    exp_e = m_err(a, sz);
    exp_d = (wr || exp_e) ? 64'd0 : m_load(d, a, sz, uns);
    @(negedge clock);
    chk1("ready_before", req_ready[d], 1'b1);
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = a;
    req_wdata[d]    = wd;
    @(posedge clock);
    #1;
    req_valid[d] = 1'b0;
    if (wr && !exp_e) m_store(d, a, sz, wd);
    n = 0;
    while (n < 20) begin
      @(negedge clock);
      n++;
      if (resp_valid[d]) break;
    end
    chk("latency", 64'(n), 64'(lat(d)));
    rd = resp_rdata[d];
    er = resp_error[d];
    chk("rdata", rd, exp_d);
    chk1("error", er, exp_e);
    @(negedge clock);
    chk1("pulse_end", resp_valid[d], 1'b0);
    chk1("ready_after", req_ready[d], 1'b1);
    chk("rdata_idle", resp_rdata[d], 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] a;
    logic [1:0]  sz;
    int          d;

    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_size[i] = 2'b00; req_unsigned[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
      m_reset(i);
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk1("rst_ready", req_ready[i], 1'b1);
      chk1("rst_resp_valid", resp_valid[i], 1'b0);
      chk("rst_rdata", resp_rdata[i], 64'd0);
      chk1("rst_error", resp_error[i], 1'b0);
    end
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // Basic load and sized store / reload (instance 0, LATENCY=2)
    access(0, 0, 2'b11, 0, 64'h28, 0, rd, er);
    chk("ld_28_const", rd, 64'd5);
    access(0, 1, 2'b00, 0, 64'h09, 64'hFF, rd, er);
    access(0, 0, 2'b00, 0, 64'h09, 0, rd, er);
    chk("lb_09_const", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    access(0, 0, 2'b00, 1, 64'h09, 0, rd, er);
    chk("lbu_09_const", rd, 64'hFF);
    access(0, 0, 2'b11, 0, 64'h08, 0, rd, er);
    chk("ld_08_const", rd, 64'h0000_0000_0000_FF01);
    access(0, 1, 2'b01, 0, 64'h0E, 64'h8001, rd, er);
    access(0, 0, 2'b01, 0, 64'h0E, 0, rd, er);
    chk("lh_0e_const", rd, 64'hFFFF_FFFF_FFFF_8001);

    // Misalignment
    access(0, 0, 2'b10, 0, 64'h0A, 0, rd, er);
    chk1("lw_0a_err_const", er, 1'b1);
    access(0, 1, 2'b11, 0, 64'h0C, 64'h1234, rd, er);
    chk1("sd_0c_err_const", er, 1'b1);
    access(0, 0, 2'b11, 0, 64'h08, 0, rd, er);
    chk("ld_08_unchanged", rd, 64'h8001_0000_0000_FF01);

    // Out of range
    access(0, 0, 2'b11, 0, 64'h2000, 0, rd, er);
    chk1("ld_2000_err_const", er, 1'b1);
    access(0, 1, 2'b00, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hAB, rd, er);
    chk1("sb_high_err_const", er, 1'b1);
    access(0, 0, 2'b11, 0, 64'h1FF8, 0, rd, er);
    chk("ld_word1023", rd, 64'd1023);

    // Back-to-back with req_valid held high (instance 1, LATENCY=3)
    @(negedge clock);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b11;
    req_unsigned[1] = 1'b0; req_addr[1] = 64'h18;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 13) req_valid[1] = 1'b0;
      chk1("b2b_ready", req_ready[1], (i % 4) == 0);
      chk1("b2b_resp", resp_valid[1], (i % 4) == 3);
      if ((i % 4) == 3) chk("b2b_data", resp_rdata[1], 64'd3);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk1("b2b_tail_resp", resp_valid[1], 1'b0);
      chk1("b2b_tail_ready", req_ready[1], 1'b1);
    end

    // Reset during WAIT after a store
    @(negedge clock);
    chk1("mid_ready_before", req_ready[0], 1'b1);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'b11;
    req_addr[0] = 64'h10; req_wdata[0] = 64'hDEAD;
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    reset[0] = 1'b1;
    m_reset(0);
    @(negedge clock);
    chk1("mid_rst_resp", resp_valid[0], 1'b0);
    reset[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk1("mid_no_resp", resp_valid[0], 1'b0);
      chk1("mid_ready", req_ready[0], 1'b1);
    end
    access(0, 0, 2'b11, 0, 64'h10, 0, rd, er);
    chk("mid_ld_10_const", rd, 64'd2);

    // Randomized accesses on both instances
    for (int i = 0; i < 80; i++) begin
      d  = i % 2;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        a = {32'($urandom), 32'($urandom)};
      end else begin
        a = 64'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      end
      access(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             {32'($urandom), 32'($urandom)}, rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
